// File: rtl/down_timer_ctrl_pkg.sv
// Shared definitions for the down-count interval timer.
//   state_t      : controller states (IDLE / RUN)
//   DEF_WIDTH    : default count width
//   DEF_PRESCALE : default clk cycles per count tick
package down_timer_ctrl_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_PRESCALE = 2;

endpackage

// File: rtl/down_timer_ctrl_tick_gen.sv
// Prescaler for the down-count timer: emits a one-cycle tick every PRESCALE
// enabled cycles.
// Ports:
//   clk   in  : rising-edge clock
//   reset in  : asynchronous, active-low
//   clr   in  : synchronous clear of the prescale count (start / stop)
//   en    in  : count enable (controller in RUN)
//   tick  out : high in the cycle the prescale count reaches PRESCALE-1
module tick_gen #(
    parameter int unsigned PRESCALE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/down_timer_ctrl.sv
// Programmable interval timer: loads a start value, decrements once per
// prescaled tick, flags expiry, and optionally reloads (periodic mode).
// Ports:
//   clk      in          : rising-edge clock
//   reset    in          : asynchronous, active-low
//   start    in          : start request, honoured in IDLE only
//   stop     in          : abort request, honoured in RUN only
//   periodic in          : captured with start; 1 = auto-reload
//   load_val in  [WIDTH] : start value captured with start; 0 = 2^WIDTH ticks
//   ack      in          : clears expired and overrun
//   q        out [WIDTH] : live count
//   busy     out         : high while running
//   done     out         : one-cycle pulse per expiry
//   expired  out         : sticky expiry flag
//   overrun  out         : sticky; expiry while expired already set
module down_timer_ctrl
    import down_timer_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_d, expired_d, overrun_d;
    logic             clr, tick;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .en   (state_q == S_RUN),
        .tick (tick)
    );

    // busy is the registered state bit itself
    assign busy = (state_q == S_RUN);

    always_comb begin
        state_d   = state_q;
        q_d       = q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        expired_d = expired;
        overrun_d = overrun;
        clr       = 1'b0;

        if (ack) begin
            expired_d = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d      = load_val;
                    reload_d = load_val;
                    mode_d   = periodic;
                    clr      = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // stop has priority over an expiry in the same cycle
                    q_d     = '0;
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end else if (tick) begin
                    if (q == WIDTH'(1)) begin
                        done_d    = 1'b1;
                        // expiry overrides a same-cycle ack for expired
                        expired_d = 1'b1;
                        if (expired && !ack) begin
                            overrun_d = 1'b1;
                        end
                        if (mode_q) begin
                            q_d = reload_q;
                        end else begin
                            q_d     = '0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        // q==0 wraps to all-ones, giving 2^WIDTH ticks
                        q_d = q - WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            q        <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state_q  <= state_d;
            q        <= q_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done     <= done_d;
            expired  <= expired_d;
            overrun  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_down_timer_ctrl.sv
module tb_down_timer_ctrl;

    localparam int W = 4;
    localparam int P = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         periodic = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         ack = 1'b0;
    logic [W-1:0] q;
    logic         busy, done, expired, overrun;

    int errors = 0;
    int checks = 0;

    down_timer_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .periodic(periodic),
        .load_val(load_val),
        .ack     (ack),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .expired (expired),
        .overrun (overrun)
    );

    always #10 clk = ~clk;

    // Behavioural model: elapsed cycles since (re)load; expiry after N*P cycles.
    bit m_run, m_mode, m_done, m_exp, m_ovr;
    int m_e, m_n, m_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_mode = 0; m_done = 0; m_exp = 0; m_ovr = 0;
            m_e = 0; m_n = 0; m_q = 0;
        end else begin
            bit x_exp, x_ovr;
            x_exp = ack ? 1'b0 : m_exp;
            x_ovr = ack ? 1'b0 : m_ovr;
            m_done = 0;
            if (!m_run) begin
                if (start) begin
                    m_run  = 1;
                    m_n    = (load_val == 0) ? (1 << W) : int'(load_val);
                    m_mode = periodic;
                    m_e    = 0;
                    m_q    = int'(load_val);
                end
            end else if (stop) begin
                m_run = 0;
                m_q   = 0;
            end else begin
                m_e++;
                if (m_e == m_n * P) begin
                    m_done = 1;
                    if (m_exp && !ack) x_ovr = 1;
                    x_exp = 1;
                    if (m_mode) begin
                        m_e = 0;
                        m_q = m_n % (1 << W);
                    end else begin
                        m_run = 0;
                        m_q   = 0;
                    end
                end else begin
                    m_q = (m_n - m_e / P) % (1 << W);
                end
            end
            m_exp = x_exp;
            m_ovr = x_ovr;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("q",       int'(q),       m_q);
        check("busy",    int'(busy),    int'(m_run));
        check("done",    int'(done),    int'(m_done));
        check("expired", int'(expired), int'(m_exp));
        check("overrun", int'(overrun), int'(m_ovr));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int lv, input bit per);
        load_val = W'(lv);
        periodic = per;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    // Counts edges until done is seen; -1 if the bound expires.
    task automatic wait_done(input int limit, output int k);
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            cyc();
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        // 1. reset held, then released idle
        repeat (2) cyc();
        check("rst_q", int'(q), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (3) cyc();
        check("idle_flags", int'({busy, done, expired, overrun}), 0);

        // 2. one-shot, load 3
        do_start(3, 1'b0);
        check("os_q_e0", int'(q), 3);
        check("os_busy", int'(busy), 1);
        wait_done(40, k);
        check("os_latency", k, 6);
        check("os_busy_fall", int'(busy), 0);
        check("os_q_end", int'(q), 0);
        repeat (3) cyc();
        check("os_expired_sticky", int'(expired), 1);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("os_ack_clr", int'(expired), 0);

        // 3. periodic, load 2
        do_start(2, 1'b1);
        wait_done(20, k);
        check("per_first", k, 4);
        check("per_ovr0", int'(overrun), 0);
        wait_done(20, k);
        check("per_period", k, 4);
        check("per_ovr1", int'(overrun), 1);
        check("per_q_reload", int'(q), 2);
        ack = 1'b1; cyc(); ack = 1'b0;
        check("per_ack", int'({expired, overrun}), 0);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("per_stop_busy", int'(busy), 0);

        // 4. load 0 means 2^W ticks
        do_start(0, 1'b0);
        check("z_q_e0", int'(q), 0);
        cyc(); cyc();
        check("z_wrap", int'(q), 15);
        wait_done(60, k);
        check("z_latency", k, 30);
        ack = 1'b1; cyc(); ack = 1'b0;

        // 5. stop while q==2, no done
        do_start(5, 1'b0);
        k = 0;
        for (int i = 0; i < 20 && q != 2; i++) cyc();
        check("stop_reach_q2", int'(q), 2);
        stop = 1'b1; cyc(); stop = 1'b0;
        check("stop_q", int'(q), 0);
        check("stop_busy", int'(busy), 0);
        check("stop_done", int'(done), 0);
        // async reset mid-run
        do_start(7, 1'b1);
        repeat (3) cyc();
        #4 reset = 1'b0;
        #1;
        check("arst_q", int'(q), 0);
        check("arst_busy", int'(busy), 0);
        cyc();
        reset = 1'b1;
        cyc();

        // 6. start+stop in IDLE enters RUN; ack coincident with expiry
        load_val = 4'd2; periodic = 1'b1; start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", int'(busy), 1);
        wait_done(20, k);
        check("ss_first", k, 4);
        repeat (3) cyc();
        ack = 1'b1; cyc(); ack = 1'b0;
        check("ackexp_done", int'(done), 1);
        check("ackexp_expired", int'(expired), 1);
        check("ackexp_overrun", int'(overrun), 0);
        stop = 1'b1; cyc(); stop = 1'b0;

        // Randomized phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 5) == 0);
            stop     = ($urandom_range(0, 24) == 0);
            ack      = ($urandom_range(0, 9) == 0);
            periodic = 1'($urandom_range(0, 1));
            load_val = W'($urandom_range(0, 15));
            if ($urandom_range(0, 599) == 0) reset = 1'b0;
            cyc();
            reset = 1'b1;
        end
        start = 1'b0; stop = 1'b0; ack = 1'b0;
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
